block_stats_calc: RTL

BLOCK_STATS_CALC -- requirements
Module: block_stats_calc

---
 rtl/block_stats_pkg.sv | 17 +
 rtl/pingpong_block_buffer.sv | 92 +++++++++
 rtl/block_stats_calc.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/block_stats_pkg.sv
// Shared constants and state encoding for the block statistics engine.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package block_stats_pkg;

  localparam int BSC_DATA_WIDTH    = 8;
  localparam int BSC_TOTAL_SAMPLES = 64;
  localparam int LOG2_SAMPLES      = $clog2(BSC_TOTAL_SAMPLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_CALC  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/pingpong_block_buffer.sv
// Two-bank block store: one bank fills while the other is replayed in arrival order.
// Latency: replay data appears one cycle after replay_start, then one pixel per cycle.
// Backpressure: none; writes are always accepted and a replay never stalls.
module pingpong_block_buffer
  import block_stats_pkg::*;
#(
  parameter int DATA_WIDTH    = BSC_DATA_WIDTH,
  parameter int TOTAL_SAMPLES = BSC_TOTAL_SAMPLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_vld,
  input  logic [DATA_WIDTH-1:0] wr_dat,
  output logic                  wr_last,
  input  logic                  replay_start,
  output logic                  rd_vld,
  output logic [DATA_WIDTH-1:0] rd_dat
);

  localparam int              PTR_W    = $clog2(TOTAL_SAMPLES);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(TOTAL_SAMPLES - 1);

  logic [DATA_WIDTH-1:0] bank_mem [2][TOTAL_SAMPLES];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic                  wr_bank_q, wr_bank_d;
  // rd_ptr doubles as the replay counter: it names the next pixel to emit and
  // wrapping back to zero marks the end of the replay.
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic                  rd_bank_q, rd_bank_d;
  logic                  rd_vld_q, rd_vld_d;
  logic [DATA_WIDTH-1:0] rd_dat_q, rd_dat_d;

  // Pointer/bank bookkeeping and replay sequencing.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    wr_bank_d = wr_bank_q;
    rd_ptr_d  = rd_ptr_q;
    rd_bank_d = rd_bank_q;
    rd_vld_d  = rd_vld_q;
    rd_dat_d  = rd_dat_q;
    wr_last   = wr_vld && (wr_ptr_q == PTR_LAST);

    if (wr_vld) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (wr_last) wr_bank_d = ~wr_bank_q;
    end

    // The completed bank is the one not filling; latch it so a later swap
    // cannot redirect a replay already under way.
    if (replay_start) begin
      rd_bank_d = ~wr_bank_q;
      rd_dat_d  = bank_mem[~wr_bank_q][0];
      rd_vld_d  = 1'b1;
      rd_ptr_d  = PTR_W'(1);
    end else if (rd_vld_q && (rd_ptr_q != '0)) begin
      rd_dat_d  = bank_mem[rd_bank_q][rd_ptr_q];
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_vld_d  = 1'b0;
      rd_dat_d  = '0;
    end
  end

  // Pixel storage; contents need no reset because replay only follows a full block.
  always_ff @(posedge clk) begin
    if (wr_vld) bank_mem[wr_bank_q][wr_ptr_q] <= wr_dat;
  end

  // Control state, cleared asynchronously so a reset drops any partial block or replay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_ptr_q  <= '0;
      rd_bank_q <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_dat_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      wr_bank_q <= wr_bank_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_bank_q <= rd_bank_d;
      rd_vld_q  <= rd_vld_d;
      rd_dat_q  <= rd_dat_d;
    end
  end

  assign rd_vld = rd_vld_q;
  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/block_stats_calc.sv
// Per-block mean/variance of a pixel stream, with the block replayed for the next stage.
// Latency: stats_ready 2 cycles after the last sample's edge; replay starts 1 cycle later.
// Backpressure: none; data_valid gaps simply pause accumulation.
module block_stats_calc
  import block_stats_pkg::*;
#(
  parameter int DATA_WIDTH    = BSC_DATA_WIDTH,
  parameter int TOTAL_SAMPLES = BSC_TOTAL_SAMPLES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    data_valid,
  output logic [2*DATA_WIDTH-1:0] mean_of_block,
  output logic [2*DATA_WIDTH-1:0] variance_of_block,
  output logic                    stats_ready,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_out_valid,
  output logic [31:0]             block_count
);

  localparam int LOG2_N = $clog2(TOTAL_SAMPLES);
  localparam int SUM_W  = DATA_WIDTH + LOG2_N;
  localparam int SQ_W   = 2*DATA_WIDTH + LOG2_N;
  localparam int OUT_W  = 2*DATA_WIDTH;

  state_e           state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [SQ_W-1:0]  sumsq_q, sumsq_d;
  logic [OUT_W-1:0] mean_q, mean_d;
  logic [OUT_W-1:0] ex2_q, ex2_d;
  logic [OUT_W-1:0] var_q, var_d;
  logic             stats_ready_q, stats_ready_d;
  logic [31:0]      block_count_q, block_count_d;
  logic [OUT_W-1:0] sq;
  logic [OUT_W-1:0] mean_sq;
  logic             wr_last;

  pingpong_block_buffer #(
    .DATA_WIDTH   (DATA_WIDTH),
    .TOTAL_SAMPLES(TOTAL_SAMPLES)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_vld      (data_valid),
    .wr_dat      (data_in),
    .wr_last     (wr_last),
    .replay_start(stats_ready_q),
    .rd_vld      (data_out_valid),
    .rd_dat      (data_out)
  );

  // Accumulation, state sequencing and the two-stage mean/variance pipeline.
  always_comb begin
    state_d       = state_q;
    sum_d         = sum_q;
    sumsq_d       = sumsq_q;
    mean_d        = mean_q;
    ex2_d         = ex2_q;
    var_d         = var_q;
    stats_ready_d = 1'b0;
    block_count_d = block_count_q;
    sq            = OUT_W'(data_in) * OUT_W'(data_in);
    // mean never exceeds DATA_WIDTH bits, so the square fits OUT_W.
    mean_sq       = mean_q * mean_q;

    if (data_valid) begin
      sum_d   = sum_q + SUM_W'(data_in);
      sumsq_d = sumsq_q + SQ_W'(sq);
    end

    case (state_q)
      ST_IDLE: begin
        if (data_valid) state_d = wr_last ? ST_CALC : ST_ACCUM;
      end
      ST_ACCUM: begin
        if (wr_last) state_d = ST_CALC;
      end
      ST_CALC: begin
        // Totals of the finished block are consumed here, so the accumulators
        // restart with whatever sample arrives this cycle.
        mean_d  = OUT_W'(sum_q[SUM_W-1:LOG2_N]);
        ex2_d   = sumsq_q[SQ_W-1:LOG2_N];
        sum_d   = data_valid ? SUM_W'(data_in) : '0;
        sumsq_d = data_valid ? SQ_W'(sq) : '0;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        var_d         = (ex2_q > mean_sq) ? (ex2_q - mean_sq) : '0;
        stats_ready_d = 1'b1;
        block_count_d = block_count_q + 32'd1;
        state_d       = data_valid ? ST_ACCUM : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // All top-level state with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      sum_q         <= '0;
      sumsq_q       <= '0;
      mean_q        <= '0;
      ex2_q         <= '0;
      var_q         <= '0;
      stats_ready_q <= 1'b0;
      block_count_q <= '0;
    end else begin
      state_q       <= state_d;
      sum_q         <= sum_d;
      sumsq_q       <= sumsq_d;
      mean_q        <= mean_d;
      ex2_q         <= ex2_d;
      var_q         <= var_d;
      stats_ready_q <= stats_ready_d;
      block_count_q <= block_count_d;
    end
  end

  // mean is published together with variance so both change on stats_ready only.
  logic [OUT_W-1:0] mean_out_q, mean_out_d;

  // Output mean register, updated alongside the variance.
  always_comb begin
    mean_out_d = mean_out_q;
    if (stats_ready_d) mean_out_d = mean_q;
  end

  // Holding register for the published mean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mean_out_q <= '0;
    else        mean_out_q <= mean_out_d;
  end

  assign mean_of_block     = mean_out_q;
  assign variance_of_block = var_q;
  assign stats_ready       = stats_ready_q;
  assign block_count       = block_count_q;

endmodule
